// File: rtl/cpu_mul_combine_pkg.sv
// Shared constants, A-stage record and arithmetic helpers for the multiplier
// partial-product combine stage.
package cpu_mul_combine_pkg;

   localparam int REGNUM_W_DEFAULT = 5;
   localparam int MUL_PP_W         = 32;
   localparam int MUL_HALF_W       = 16;

   // The regnum field width follows the package default register index width.
   typedef struct packed {
      logic [MUL_PP_W-1:0]         p1;
      logic [MUL_HALF_W-1:0]       sum16;
      logic [REGNUM_W_DEFAULT-1:0] regnum;
      logic                        valid;
   } a_stage_t;

   // Only the low halves of the cross products can reach the low 32 result bits.
   function automatic logic [MUL_HALF_W-1:0] mul_sum16(input logic [MUL_PP_W-1:0] p2,
                                                       input logic [MUL_PP_W-1:0] p3);
      return p2[MUL_HALF_W-1:0] + p3[MUL_HALF_W-1:0];
   endfunction

   function automatic logic [MUL_PP_W-1:0] mul_combine(input logic [MUL_PP_W-1:0]   p1,
                                                       input logic [MUL_HALF_W-1:0] sum16);
      return p1 + {sum16, {MUL_HALF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cpu_mul_hazard_cmp.sv
// Combinational match of one in-flight mul destination against the two
// decode-stage source operands.
module cpu_mul_hazard_cmp #(
   parameter int REGNUM_W = 5
) (
   input  logic                valid,
   input  logic [REGNUM_W-1:0] regnum,
   input  logic [REGNUM_W-1:0] src_a,
   input  logic [REGNUM_W-1:0] src_b,
   input  logic                src_a_used,
   input  logic                src_b_used,
   output logic                hit
);

   always_comb begin
      // NOTE: default assigned first so no path leaves hit unassigned (no latch).
      hit = 1'b0;
      if (valid && regnum != '0) begin
         hit = (src_a_used && src_a == regnum) || (src_b_used && src_b == regnum);
      end
   end

endmodule

// File: rtl/cpu_mul_combine.sv
// Reduces the three registered 16x16 partial products to the low 32-bit
// product across the A and W stages, with flush tracking and decode hazard.
module cpu_mul_combine
   import cpu_mul_combine_pkg::*;
#(
   parameter int REGNUM_W    = REGNUM_W_DEFAULT,
   parameter int PIPE_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [MUL_PP_W-1:0] M_mul_cell_p1,
   input  logic [MUL_PP_W-1:0] M_mul_cell_p2,
   input  logic [MUL_PP_W-1:0] M_mul_cell_p3,
   input  logic                M_mul_valid,
   input  logic [REGNUM_W-1:0] M_dst_regnum,
   input  logic                A_en,
   input  logic                W_en,
   input  logic                A_flush,
   input  logic [REGNUM_W-1:0] D_src_a,
   input  logic [REGNUM_W-1:0] D_src_b,
   input  logic                D_src_a_used,
   input  logic                D_src_b_used,
   output logic [MUL_PP_W-1:0] W_mul_result,
   output logic                W_mul_valid,
   output logic [REGNUM_W-1:0] W_mul_regnum,
   output logic                D_mul_hazard
);

   logic m_hit;
   logic a_hit;

   cpu_mul_hazard_cmp #(.REGNUM_W(REGNUM_W)) u_m_cmp (
      .valid      (M_mul_valid),
      .regnum     (M_dst_regnum),
      .src_a      (D_src_a),
      .src_b      (D_src_b),
      .src_a_used (D_src_a_used),
      .src_b_used (D_src_b_used),
      .hit        (m_hit)
   );

   generate
      if (PIPE_STAGES == 2) begin : g_two_stage
         a_stage_t a_q;
         logic     a_live;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_q <= '0;
            end else begin
               // NOTE: non-blocking assignments so every register samples pre-edge values.
               if (A_en) begin
                  a_q.p1     <= M_mul_cell_p1;
                  a_q.sum16  <= mul_sum16(M_mul_cell_p2, M_mul_cell_p3);
                  a_q.regnum <= M_dst_regnum;
               end
               // Flush beats a load; a drain into W without refill retires A.
               if (A_flush)   a_q.valid <= 1'b0;
               else if (A_en) a_q.valid <= M_mul_valid;
               else if (W_en) a_q.valid <= 1'b0;
            end
         end

         assign a_live = a_q.valid & ~A_flush;

         cpu_mul_hazard_cmp #(.REGNUM_W(REGNUM_W)) u_a_cmp (
            .valid      (a_live),
            .regnum     (a_q.regnum),
            .src_a      (D_src_a),
            .src_b      (D_src_b),
            .src_a_used (D_src_a_used),
            .src_b_used (D_src_b_used),
            .hit        (a_hit)
         );

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               W_mul_result <= '0;
               W_mul_regnum <= '0;
               W_mul_valid  <= 1'b0;
            end else if (W_en) begin
               W_mul_result <= mul_combine(a_q.p1, a_q.sum16);
               W_mul_regnum <= a_q.regnum;
               W_mul_valid  <= a_live;
            end
         end
      end else begin : g_one_stage
         // No A state: the full combine registers straight into W on A_en.
         assign a_hit = 1'b0;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               W_mul_result <= '0;
               W_mul_regnum <= '0;
               W_mul_valid  <= 1'b0;
            end else if (A_en) begin
               W_mul_result <= mul_combine(M_mul_cell_p1,
                                           mul_sum16(M_mul_cell_p2, M_mul_cell_p3));
               W_mul_regnum <= M_dst_regnum;
               W_mul_valid  <= M_mul_valid;
            end
         end
      end
   endgenerate

   // W is covered by the register-file bypass, so only M and A can stall decode.
   assign D_mul_hazard = m_hit | a_hit;

endmodule
